snake_sub_scheduler: RTL and testbench



---
 rtl/snake_pkg.sv | 10 +
 rtl/fiveBitSubtractor.sv | 17 +
 rtl/snake_sub_scheduler.sv | 69 ++++++
 tb/tb_snake_sub_scheduler.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared widths, requester IDs and scheduler state encoding for the snake datapath
package snake_pkg;
  localparam int SNAKE_COORD_W = 5;
  localparam int SUB_SCHED_MAX_REQ = 4;
  localparam logic [1:0] REQ_DX = 2'd0;
  localparam logic [1:0] REQ_DY = 2'd1;
  localparam logic [1:0] REQ_WALL = 2'd2;
  localparam logic [1:0] REQ_BODY = 2'd3;
  typedef enum logic {S_IDLE, S_HOLD} state_t;
endpackage

// File: rtl/fiveBitSubtractor.sv
// fiveBitSubtractor: ripple-borrow a - b modulo 32, no borrow out
module fiveBitSubtractor
  import snake_pkg::*;
(
  input  logic [SNAKE_COORD_W-1:0] a,
  input  logic [SNAKE_COORD_W-1:0] b,
  output logic [SNAKE_COORD_W-1:0] d
);
  logic [SNAKE_COORD_W-1:0] br;
  assign br[0] = 1'b0;
  for (genvar i = 0; i < SNAKE_COORD_W; i++) begin : g_bit
    assign d[i] = a[i] ^ b[i] ^ br[i];
    if (i < SNAKE_COORD_W - 1) begin : g_br
      assign br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
  end
endmodule

// File: rtl/snake_sub_scheduler.sv
// snake_sub_scheduler: round-robin time-share of one subtractor; SUB_SCHED_ZERO_FLAG_EN adds RSP_ZERO
module snake_sub_scheduler
  import snake_pkg::*;
#(
  parameter int N_REQ = SUB_SCHED_MAX_REQ,
  parameter int W = SNAKE_COORD_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ_VALID,
  output logic [N_REQ-1:0] REQ_READY,
  input  logic [N_REQ*W-1:0] REQ_A,
  input  logic [N_REQ*W-1:0] REQ_B,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [1:0]       RSP_ID,
  output logic [W-1:0]     RSP_D
`ifdef SUB_SCHED_ZERO_FLAG_EN
  ,
  output logic             RSP_ZERO
`endif
);
  state_t state;
  logic [1:0] ptr, win;
  logic [N_REQ-1:0] rot;
  logic [W-1:0] a, b, d;
  logic acc, take;
  assign rot = N_REQ'({REQ_VALID, REQ_VALID} >> ptr);
  // first valid requester at or after ptr; scanning downward leaves the nearest one
  always_comb begin
    win = ptr;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (rot[k]) win = 2'((int'(ptr) + k) % N_REQ);
  end
  // route the winner's operands into the shared subtractor
  always_comb begin
    a = '0;
    b = '0;
    for (int i = 0; i < N_REQ; i++)
      if (2'(i) == win) begin
        a = REQ_A[i*W +: W];
        b = REQ_B[i*W +: W];
      end
  end
  assign acc = !RST && (state == S_IDLE || RSP_READY);
  assign REQ_READY = acc ? N_REQ'(1) << win : '0;
  assign take = |(REQ_VALID & REQ_READY);
  assign RSP_VALID = state == S_HOLD;
  fiveBitSubtractor u_sub (.a(a), .b(b), .d(d));
  // response holding FSM: capture on accept, release when consumed with nothing pending
  always_ff @(posedge CLK)
    if (RST) begin
      state <= S_IDLE;
      ptr <= '0;
      RSP_D <= '0;
      RSP_ID <= '0;
`ifdef SUB_SCHED_ZERO_FLAG_EN
      RSP_ZERO <= 1'b0;
`endif
    end else if (take) begin
      state <= S_HOLD;
      ptr <= 2'((int'(win) + 1) % N_REQ);
      RSP_D <= d;
      RSP_ID <= win;
`ifdef SUB_SCHED_ZERO_FLAG_EN
      RSP_ZERO <= d == '0;
`endif
    end else if (RSP_READY) state <= S_IDLE;
endmodule

// File: tb/tb_snake_sub_scheduler.sv
// tb_snake_sub_scheduler: scoreboard bench with a behavioural round-robin model
module tb_snake_sub_scheduler;
  localparam int N = 4;
  localparam int W = 5;
  typedef struct { int id; int d; } exp_t;
  logic CLK = 0, RST = 1, RSP_READY = 1;
  logic [N-1:0] REQ_VALID = '0, REQ_READY;
  logic [N*W-1:0] REQ_A = '0, REQ_B = '0;
  logic RSP_VALID;
  logic [1:0] RSP_ID;
  logic [W-1:0] RSP_D;
`ifdef SUB_SCHED_ZERO_FLAG_EN
  logic RSP_ZERO;
`endif
  exp_t q[$];
  int checks = 0, failures = 0;
  int oa[N], ob[N];
  int m_ptr = 0;
  bit m_hold = 0, rnd = 0;
  snake_sub_scheduler #(.N_REQ(N), .W(W)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_ID(RSP_ID), .RSP_D(RSP_D)
`ifdef SUB_SCHED_ZERO_FLAG_EN
    , .RSP_ZERO(RSP_ZERO)
`endif
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic [N-1:0] v, input logic rr);
    int win;
    bit found, acc, tk;
    logic [N-1:0] er;
    @(negedge CLK);
    if (rnd)
      for (int i = 0; i < N; i++)
        if (!v[i]) begin
          oa[i] = $urandom_range(0, 31);
          ob[i] = $urandom_range(0, 31);
        end
    RST = r;
    REQ_VALID = v;
    RSP_READY = rr;
    for (int i = 0; i < N; i++) begin
      REQ_A[i*W +: W] = 5'(oa[i]);
      REQ_B[i*W +: W] = 5'(ob[i]);
    end
    #1;
    acc = !r && (!m_hold || rr);
    win = m_ptr;
    found = 0;
    for (int k = 0; k < N; k++)
      if (!found && v[(m_ptr + k) % N]) begin
        win = (m_ptr + k) % N;
        found = 1;
      end
    er = acc ? N'(1) << win : '0;
    chk("req_ready", int'(REQ_READY), int'(er));
    tk = acc && found;
    if (tk) q.push_back('{win, (oa[win] - ob[win]) & 31});
    @(posedge CLK);
    if (r) begin
      m_hold = 0;
      m_ptr = 0;
    end else if (tk) begin
      m_hold = 1;
      m_ptr = (win + 1) % N;
      if (rnd) begin
        oa[win] = $urandom_range(0, 31);
        ob[win] = $urandom_range(0, 31);
      end
    end else if (rr) m_hold = 0;
  endtask
  // monitor: pop on every newly presented response, check stability while stalled
  initial begin
    bit pv = 0;
    int pd = 0, pid = 0;
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (pv && !RST && !RSP_READY) begin
        chk("hold_valid", int'(RSP_VALID), 1);
        chk("hold_d", int'(RSP_D), pd);
        chk("hold_id", int'(RSP_ID), pid);
      end else if (RSP_VALID === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual id=%0d d=%0d required=none", RSP_ID, RSP_D);
        end else begin
          e = q.pop_front();
          chk("rsp_id", int'(RSP_ID), e.id);
          chk("rsp_d", int'(RSP_D), e.d);
`ifdef SUB_SCHED_ZERO_FLAG_EN
          chk("rsp_zero", int'(RSP_ZERO), int'(e.d == 0));
`endif
        end
      end
      pv = RSP_VALID === 1'b1;
      pd = int'(RSP_D);
      pid = int'(RSP_ID);
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < N; i++) begin
      oa[i] = 0;
      ob[i] = 0;
    end
    step(1, 4'b0000, 1);
    step(1, 4'b0000, 1);
    #2;
    chk("reset_valid", int'(RSP_VALID), 0);
    chk("reset_d", int'(RSP_D), 0);
    chk("reset_id", int'(RSP_ID), 0);
`ifdef SUB_SCHED_ZERO_FLAG_EN
    chk("reset_zero", int'(RSP_ZERO), 0);
`endif
    oa[0] = 20; ob[0] = 7;
    step(0, 4'b0001, 1);
    step(0, 4'b0000, 1);
    oa[0] = 3; ob[0] = 5;
    step(0, 4'b0001, 1);
    oa[0] = 17; ob[0] = 17;
    step(0, 4'b0001, 1);
    step(0, 4'b0000, 1);
    step(1, 4'b0000, 1);
    for (int i = 0; i < N; i++) begin
      oa[i] = i * 9 + 2;
      ob[i] = 30 - i * 4;
    end
    for (int c = 0; c < 5; c++) step(0, 4'b1111, 1);
    for (int c = 0; c < 3; c++) step(0, 4'b0000, 0);
    step(0, 4'b0100, 1);
    step(0, 4'b0000, 1);
    step(0, 4'b0010, 0);
    step(0, 4'b0010, 0);
    step(1, 4'b0010, 0);
    #2;
    chk("midreset_valid", int'(RSP_VALID), 0);
    step(0, 4'b0010, 1);
    step(0, 4'b0000, 1);
    step(0, 4'b0001, 1);
    step(0, 4'b0011, 1);
    step(0, 4'b0000, 1);
    rnd = 1;
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 49) == 0, 4'($urandom), $urandom_range(0, 9) < 7);
    rnd = 0;
    for (int c = 0; c < 3; c++) step(0, 4'b0000, 1);
    #2;
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
